// File: rtl/keypad_scan_debounce.sv
// Matrix keypad front end: column strobing, row synchronisation, whole-frame debounce,
// and single-event press reporting with an encoded key index.
module keypad_scan_debounce #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int CODE_W          = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ROWS-1:0]        row_n,
    output logic [COLS-1:0]        col_n,
    output logic [ROWS*COLS-1:0]   key_state,
    output logic                   key_valid,
    output logic [CODE_W-1:0]      key_code,
    output logic                   multi_key
);

    localparam int N  = ROWS * COLS;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int MW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;

    if ((2 ** CODE_W) < N) begin : g_code_w_check
        $error("keypad_scan_debounce: CODE_W too small for ROWS*COLS keys");
    end

    typedef enum logic [1:0] {IDLE, SCAN, FRAME_END} state_t;

    state_t            state_q, state_d;
    logic [ROWS-1:0]   sync1_q, sync2_q;
    logic [CW-1:0]     col_q, col_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [N-1:0]      frame_q, frame_d;
    logic [N-1:0]      prev_q, prev_d;
    logic [MW-1:0]     match_q, match_d;
    logic [N-1:0]      key_state_q, key_state_d;
    logic              key_valid_q, key_valid_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              multi_q, multi_d;

    logic [ROWS-1:0]   pressed;
    logic [N-1:0]      new_keys;
    logic              same_frame;
    logic              do_update;
    logic [7:0]        ones;

    assign pressed    = ~sync2_q;
    assign new_keys   = frame_q & ~key_state_q;
    assign same_frame = (frame_q == prev_q);
    assign do_update  = (DEBOUNCE_FRAMES == 1) ||
                        (same_frame && (match_q == MW'(DEBOUNCE_FRAMES - 1)));

    assign col_n     = (state_q == IDLE) ? '1 : ~(COLS'(1) << col_q);
    assign key_state = key_state_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign multi_key = multi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= '1;
            sync2_q     <= '1;
            col_q       <= '0;
            dwell_q     <= '0;
            frame_q     <= '0;
            prev_q      <= '0;
            match_q     <= '0;
            key_state_q <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            multi_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= row_n;
            sync2_q     <= sync1_q;
            col_q       <= col_d;
            dwell_q     <= dwell_d;
            frame_q     <= frame_d;
            prev_q      <= prev_d;
            match_q     <= match_d;
            key_state_q <= key_state_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            multi_q     <= multi_d;
        end
    end

    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + 8'(frame_q[i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        dwell_d     = dwell_q;
        frame_d     = frame_q;
        prev_d      = prev_q;
        match_d     = match_q;
        key_state_d = key_state_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        multi_d     = multi_q;

        case (state_q)
            IDLE: begin
                state_d = SCAN;
            end
            SCAN: begin
                if (dwell_q == DW'(SCAN_DIV - 1)) begin
                    dwell_d = '0;
                    for (int r = 0; r < ROWS; r++) begin
                        frame_d[r*COLS + int'(col_q)] = pressed[r];
                    end
                    if (col_q == CW'(COLS - 1)) begin
                        state_d = FRAME_END;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            FRAME_END: begin
                state_d = SCAN;
                col_d   = '0;
                prev_d  = frame_q;
                if (same_frame) begin
                    if (match_q != MW'(DEBOUNCE_FRAMES - 1)) begin
                        match_d = match_q + 1'b1;
                    end
                end else begin
                    match_d = '0;
                end
                if (do_update) begin
                    key_state_d = frame_q;
                    multi_d     = (ones > 8'd1);
                    // Only the lowest newly pressed key is reported; others stay silent.
                    for (int i = N - 1; i >= 0; i--) begin
                        if (new_keys[i]) begin
                            key_valid_d = 1'b1;
                            key_code_d  = CODE_W'(i);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Parametrised matrix-keypad front end: drives active-low column strobes, samples active-low row returns, debounces the whole matrix, and emits a one-cycle key event with an encoded key code.
- Generalises the fixed 4x4 combinational key remap to ROWS x COLS.
- Adds scanning, synchronisation, frame-based debounce, press detection and multi-key flagging.
- Sits between the board keypad pins and the input FSMs; downstream logic consumes key_valid/key_code only.

Parameters:
- ROWS, 4, number of row inputs (1..8)
- COLS, 4, number of column strobes (1..8)
- SCAN_DIV, 100000, clock cycles each column is driven (>=4)
- DEBOUNCE_FRAMES, 4, consecutive identical frames required before the stable state updates (>=1)
- CODE_W, 6, key_code width; must satisfy 2^CODE_W >= ROWS*COLS

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- row_n  in  ROWS  keypad row returns, active-low (pulled up), asynchronous to clk
- col_n  out  COLS  column strobes, active-low one-hot while scanning
- key_state  out  ROWS*COLS  debounced pressed vector, active-high; bit index = r*COLS + c
- key_valid  out  1  one-cycle pulse on a debounced new press
- key_code  out  CODE_W  index of the reported key; held until the next key_valid
- multi_key  out  1  high while more than one bit of key_state is set

Behaviour:
- Reset (async assert, sync release via clk): col_n = all ones, key_state = 0, key_valid = 0, key_code = 0, multi_key = 0; all counters, snapshots and synchroniser flops = 0/idle.
- First rising edge after reset release: col_n = ~1 (column 0 driven).
- row_n passes through a 2-flop synchroniser (reset value all ones) before any use; the internal pressed bit is the inverse of the synchronised row_n.
- Scan FSM:
  - States: SCAN (per column), FRAME_END (one cycle).
  - A dwell counter counts 0..SCAN_DIV-1 while column c is driven. At count SCAN_DIV-1, the synchronised rows are written into frame bits r*COLS+c.
  - Then c increments. On c = COLS-1 the FSM enters FRAME_END; col_n stays on column COLS-1 during FRAME_END, then wraps to column 0 and SCAN resumes.
  - Frame period = COLS*SCAN_DIV + 1 cycles.
- Debounce (evaluated in FRAME_END):
  - If the frame equals the previous frame, match_cnt increments, saturating at DEBOUNCE_FRAMES-1. Otherwise match_cnt = 0.
  - The frame is always stored as the previous frame.
  - When the frame equals the previous frame and match_cnt has already reached DEBOUNCE_FRAMES-1, key_state <= frame on the next edge.
  - DEBOUNCE_FRAMES = 1 means every frame updates key_state.
- Press detect:
  - new = frame & ~key_state, evaluated in the same cycle key_state updates.
  - If new != 0, key_valid pulses high for exactly one cycle, coincident with the key_state update. key_code = the lowest set index of new.
  - Other simultaneously new keys are not reported (no queue). They remain in key_state and are never reported later unless released and re-pressed.
- Releases update key_state only; they never pulse key_valid and never change key_code.
- multi_key = popcount(key_state) > 1, registered, updated together with key_state.
- A held key produces no repeat events.
- Any frame that differs restarts debounce; key_state is retained during bounce.
- rst_n asserted mid-frame: immediate return to reset values. Scanning restarts from column 0 with an empty history, so a key held through reset is re-reported after DEBOUNCE_FRAMES identical frames following the first full frame.
- Synthesis must reject parameter values that violate the CODE_W constraint.

Test Plan:
- Params ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_FRAMES=3, so frame = 17 cycles. Reset release with row_n = 4'hF -> col_n walks 1110, 1101, 1011, 0111, each for 4 cycles; key_valid never asserts; key_state = 0.
- Model key r1,c2 pressed (row_n[1] = 0 whenever col_n[2] = 0) -> after 3 identical frames, key_state = 16'h0040, key_code = 6, key_valid is a single-cycle pulse, multi_key = 0; holding 10 more frames gives no further pulses.
- Bounce r1,c2 alternately every frame for 5 frames, then hold -> no key_valid during bounce; the pulse comes 3 stable frames after bouncing stops.
- Press r0,c3 and r2,c0 in the same frame -> one key_valid with key_code = 3 and key_state = 16'h0108, multi_key = 1. Release r0,c3 -> no pulse, key_state = 16'h0100, multi_key = 0, key_code stays 3.
- Assert rst_n low mid-frame while a key is debounced -> all outputs are 0 and col_n = all ones immediately. After release with the key still held, key_valid fires once with the same code.
- Params ROWS=2, COLS=3, DEBOUNCE_FRAMES=1: press r1,c2 -> key_code = 5, key_valid in the first FRAME_END after capture.
